// File: rtl/led_pkg.sv
// Shared constants and types for the LED rotator/fader path.
package led_pkg;

    localparam int LED_N            = 16;
    localparam int FADE_DIV_DEFAULT = 250000;
    localparam int LEVEL_W_DEFAULT  = 4;

    typedef logic [LED_N-1:0] led_vec_t;

endpackage

// File: rtl/led_fader_chan.sv
// One LED channel: brightness level with fade-out, rendered as PWM against
// the shared counter.
module led_fader_chan #(
    parameter int LEVEL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               pat,
    input  logic               fade_tick,
    input  logic [LEVEL_W-1:0] pwm_cnt,
    output logic               led_out
);

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] level_next;

    // A lit pattern bit outranks a fade step landing on the same cycle.
    always_comb begin
        level_next = level;
        if (!enable) begin
            level_next = '0;
        end else if (pat) begin
            level_next = LEVEL_MAX;
        end else if (fade_tick && (level != '0)) begin
            level_next = level - LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= '0;
            led_out <= 1'b0;
        end else begin
            level   <= level_next;
            led_out <= enable && (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/led_fader.sv
// Turns the rotator's LED pattern into per-LED PWM brightness with a
// decaying comet tail behind each lit position.
module led_fader
    import led_pkg::*;
#(
    parameter int FADE_DIV = FADE_DIV_DEFAULT,
    parameter int LEVEL_W  = LEVEL_W_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     enable,
    input  led_vec_t pattern,
    output led_vec_t led_out
);

    // PWM period is LEVEL_MAX cycles so that level LEVEL_MAX is solidly on.
    localparam logic [LEVEL_W-1:0] PWM_LAST = LEVEL_W'((2 ** LEVEL_W) - 2);
    localparam logic [31:0]        DIV_LAST = 32'(FADE_DIV - 1);

    led_vec_t           pat_q;
    logic [LEVEL_W-1:0] pwm_cnt;
    logic [31:0]        div_cnt;
    logic               fade_tick;

    assign fade_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= '0;
        end else begin
            pat_q <= pattern;
        end
    end

    // Both counters are parked at zero while disabled so re-enable starts a fresh phase.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            pwm_cnt <= '0;
            div_cnt <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + LEVEL_W'(1);
            div_cnt <= fade_tick ? '0 : div_cnt + 32'd1;
        end
    end

    for (genvar i = 0; i < LED_N; i++) begin : g_chan
        led_fader_chan #(
            .LEVEL_W(LEVEL_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .enable   (enable),
            .pat      (pat_q[i]),
            .fade_tick(fade_tick),
            .pwm_cnt  (pwm_cnt),
            .led_out  (led_out[i])
        );
    end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with FADE_DIV=4, LEVEL_W=4 (LEVEL_MAX=15);
// k counts clock edges from the enable-restart edge used as time reference.
module tb_led_fader;
    import led_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     enable;
    led_vec_t pattern;
    led_vec_t led_out;

    int total = 0;
    int bad   = 0;
    int k     = 0;
    int win_cnt [5];

    logic [3:0]  level0;
    logic [3:0]  level3;
    logic [3:0]  pwm_cnt;
    logic [31:0] div_cnt;

    led_fader #(
        .FADE_DIV(4),
        .LEVEL_W (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .pattern(pattern),
        .led_out(led_out)
    );

    assign level0  = dut.g_chan[0].u_chan.level;
    assign level3  = dut.g_chan[3].u_chan.level;
    assign pwm_cnt = dut.pwm_cnt;
    assign div_cnt = dut.div_cnt;

    always #5 clk = ~clk;

    task automatic next_edge();
        @(negedge clk);
        k++;
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input led_vec_t p);
        rst     = r;
        enable  = e;
        pattern = p;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (k=%0d)", tag, observed, expected, k);
        end
    endtask

    initial begin
        for (int w = 0; w < 5; w++) win_cnt[w] = 0;

        // Reset held with every pattern bit requested.
        apply_stimulus(1'b1, 1'b1, 16'hFFFF);
        repeat (3) begin
            next_edge();
            check_output("reset_hold", 32'(led_out), 32'h0);
        end
        apply_stimulus(1'b0, 1'b1, 16'hFFFF);
        next_edge();
        check_output("reset_release", 32'(led_out), 32'h0);
        next_edge();
        check_output("rise_latency_1", 32'(led_out), 32'h0);
        repeat (8) begin
            next_edge();
            check_output("all_on", 32'(led_out), 32'hFFFF);
        end

        // Blank for one cycle so every level restarts from 0, then steady LED0.
        apply_stimulus(1'b0, 1'b0, 16'h0001);
        next_edge();
        check_output("enable_low_blank", 32'(led_out), 32'h0);
        k = 0;
        apply_stimulus(1'b0, 1'b1, 16'h0001);
        next_edge();
        check_output("restart_blank", 32'(led_out), 32'h0);
        while (k < 20) begin
            next_edge();
            check_output("steady_on", 32'(led_out), 32'h0001);
        end

        // LED0 fades while LED1 lights; windows of 15 cycles start at k=22.
        apply_stimulus(1'b0, 1'b1, 16'h0002);
        while (k < 96) begin
            next_edge();
            if (k <= 22) check_output("switch_latency", 32'(led_out), 32'h0001);
            else         check_output("led1_solid", 32'(led_out[1]), 32'h1);
            if (k >= 22) win_cnt[(k - 22) / 15] += int'(led_out[0]);
            if (k >= 85) check_output("led0_dark", 32'(led_out[0]), 32'h0);
            if (k == 24 || k == 27) check_output("fade_level_14", 32'(level0), 32'd14);
            if (k == 28) check_output("fade_level_13", 32'(level0), 32'd13);
            if (k == 80) check_output("fade_level_0", 32'(level0), 32'd0);
        end
        check_output("window0_count", 32'(win_cnt[0]), 32'd13);
        for (int w = 1; w < 5; w++) begin
            check_output("window_monotonic", 32'(win_cnt[w] <= win_cnt[w-1]), 32'h1);
        end
        check_output("window4_count", 32'(win_cnt[4]), 32'd0);

        // Relight LED0 for one cycle, let it fade to 5, then re-request on a tick.
        apply_stimulus(1'b0, 1'b1, 16'h0003);
        next_edge();
        apply_stimulus(1'b0, 1'b1, 16'h0002);
        while (k < 138) begin
            next_edge();
            if (k == 136) check_output("fade_to_5", 32'(level0), 32'd5);
        end
        apply_stimulus(1'b0, 1'b1, 16'h0003);
        next_edge();
        check_output("pre_collision_level", 32'(level0), 32'd5);
        next_edge();
        check_output("collision_level", 32'(level0), 32'd15);
        while (k < 144) begin
            next_edge();
            check_output("collision_solid", 32'(led_out[0]), 32'h1);
        end

        // Fade LED0 to 8, then drop enable for one cycle.
        apply_stimulus(1'b0, 1'b1, 16'h0002);
        while (k < 173) next_edge();
        check_output("fade_to_8", 32'(level0), 32'd8);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        next_edge();
        check_output("enable_drop_blank", 32'(led_out), 32'h0);
        check_output("enable_drop_level", 32'(level0), 32'd0);
        check_output("enable_drop_pwm", 32'(pwm_cnt), 32'd0);
        check_output("enable_drop_div", div_cnt, 32'd0);
        apply_stimulus(1'b0, 1'b1, 16'h0000);
        while (k < 195) begin
            next_edge();
            check_output("reenable_dark", 32'(led_out), 32'h0);
        end

        // LED3 lit for one cycle at k=196, fades to 10 by k=214, then reset.
        apply_stimulus(1'b0, 1'b1, 16'h0008);
        next_edge();
        apply_stimulus(1'b0, 1'b1, 16'h0000);
        while (k < 215) begin
            next_edge();
            if (k == 210) check_output("led3_pwm_high", 32'(led_out), 32'h0008);
        end
        check_output("fade_to_10", 32'(level3), 32'd10);
        check_output("led3_pwm_low", 32'(led_out), 32'h0);
        apply_stimulus(1'b1, 1'b1, 16'h0000);
        next_edge();
        check_output("reset_mid_fade_out", 32'(led_out), 32'h0);
        check_output("reset_mid_fade_level", 32'(level3), 32'd0);
        check_output("reset_mid_fade_pwm", 32'(pwm_cnt), 32'd0);
        check_output("reset_mid_fade_div", div_cnt, 32'd0);
        apply_stimulus(1'b0, 1'b1, 16'h0000);
        next_edge();
        check_output("pwm_restart", 32'(pwm_cnt), 32'd1);
        check_output("post_reset_dark", 32'(led_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_fader.md
# led_fader

Downstream stage of the LED rotator: takes the 16-bit LED pattern it produces and drives the physical LED pins. Each LED has its own brightness level, rendered as PWM. A lit pattern bit forces full brightness. A cleared bit lets brightness decay step by step, giving a fading "comet tail" behind the rotating light. Sits between the rotator's `led` register and the board LED pins.

## Interface
- `FADE_DIV`, default 250000: clock cycles per fade step; legal range ≥1.
- `LEVEL_W`, default 4: brightness level width; LEVEL_MAX = 2^LEVEL_W − 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high; clock clk.
- `enable`  in  1  fader enable; 0 blanks all LEDs.
- `pattern`  in  16  LED pattern from the rotator; bit i = LED i requested on.
- `led_out`  out  16  PWM-modulated LED drive, registered.

## Operation
- Input register `pat_q` samples `pattern` every cycle.
- PWM counter `pwm_cnt` (LEVEL_W bits):
  - counts 0..LEVEL_MAX−1, then wraps to 0;
  - PWM period = LEVEL_MAX cycles.
- Fade divider `div_cnt` (32 bits):
  - counts 0..FADE_DIV−1, then wraps;
  - `fade_tick` = (div_cnt == FADE_DIV−1);
  - with FADE_DIV=1, `fade_tick` is high every cycle.
- Per LED i, `level[i]` (LEVEL_W bits), priority order:
  1. `!enable` → 0.
  2. `pat_q[i]` → LEVEL_MAX.
  3. `fade_tick && level[i]!=0` → level[i]−1.
  4. else hold.
- A set pattern bit on a `fade_tick` cycle wins: level = LEVEL_MAX, no decrement.
- Output: `led_out[i]` <= enable && (pwm_cnt < level[i]).
  - level LEVEL_MAX → constantly 1.
  - level 0 → constantly 0.
  - level k → exactly k high cycles per LEVEL_MAX-cycle window.
- Level saturates at 0; it never wraps below 0.
- `enable` low:
  - `pwm_cnt` and `div_cnt` held at 0;
  - levels cleared;
  - `led_out` = 0.
- After `enable` returns high, the counters restart from 0 and levels start from 0.

## Timing
- Reset values: `pat_q`=0, `pwm_cnt`=0, `div_cnt`=0, all `level`=0, `led_out`=0.
- Rise path: `pattern` bit rises, sampled at edge n.
  - `pat_q` at n; `level`=LEVEL_MAX at edge n+1; `led_out` bit=1 at edge n+2.
  - Latency is 2 cycles after the sampling edge, independent of PWM phase.
- Fall path: bit falls, sampled at edge n.
  - `pat_q`=0 after edge n; level holds LEVEL_MAX until the next `fade_tick`.
  - Level reaches 0 after LEVEL_MAX ticks: at most LEVEL_MAX×FADE_DIV cycles.
- `enable` falling: levels and counters cleared at the next edge; `led_out` is 0 after that same edge.
- `rst` mid-fade: all state to reset values at the next edge; `rst` has priority over `enable`.
- No handshake: `pattern` is level-sampled every cycle, so glitch-free input is the upstream's responsibility. The rotator output is registered, so it qualifies.

## Structure
- Shared package `led_pkg`:
  - LED_N = 16;
  - default FADE_DIV and LEVEL_W;
  - typedef `led_vec_t` (16-bit).
- Sub-module `led_fader_chan`, instantiated 16× via generate. It contains:
  - one `level` register;
  - priority update logic;
  - PWM comparator;
  - output flop.
- Top level holds `pat_q`, `pwm_cnt`, `div_cnt` and `fade_tick`.

## Test plan
Bench parameters: FADE_DIV=4, LEVEL_W=4 (LEVEL_MAX=15).
1. Reset: assert `rst` 3 cycles with `pattern`=0xFFFF → `led_out`=0x0000 throughout and the cycle after release; from 2 cycles after the first sampling edge, `led_out`=0xFFFF constantly.
2. Steady on: `enable`=1, `pattern`=0x0001 held → `led_out`=0x0001 every cycle from 2 cycles after the sampling edge.
3. Fade: after 2, switch to `pattern`=0x0002 →
   - LED0 level drops by 1 per 4 cycles;
   - count of high cycles in each 15-cycle window is monotonically non-increasing;
   - LED0 is constantly 0 within 60+3 cycles;
   - LED1 is solid after 2 cycles.
4. Collision: LED0 at level 5, assert `pattern[0]` so `pat_q[0]` rises on a `fade_tick` cycle → level=15 (no decrement), LED0 solid.
5. Enable drop mid-fade: LED0 at level 8, `enable`=0 for 1 cycle → `led_out`=0 next cycle; after re-enable with `pattern`=0, LED0 stays 0.
6. Reset mid-fade: LED3 at level 10 during PWM window, pulse `rst` 1 cycle → `led_out`=0 and all levels 0 after the edge; `pwm_cnt` restarts at 0.
